// File: rtl/decode_stage_ctl.sv
`timescale 1ns/1ps
// RV32 decode stage with ID/EX register: instruction decode, register file with
// optional W->D write-through, load-use bubble insertion, hold/flush, bubble counter.
module decode_stage_ctl #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              InstrD,
  input  logic [XLEN-1:0]          PCD,
  input  logic [XLEN-1:0]          PCPlus4D,
  input  logic                     ValidD,
  input  logic                     HoldE,
  input  logic                     FlushE,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic [XLEN-1:0]          ResultW,
  output logic                     StallD,
  output logic                     ValidE,
  output logic                     RegWriteE,
  output logic                     ALUSrcE,
  output logic                     MemWriteE,
  output logic                     BranchE,
  output logic                     JumpE,
  output logic [1:0]               ResultSrcE,
  output logic [2:0]               ALUControlE,
  output logic [$clog2(NREGS)-1:0] Rs1E,
  output logic [$clog2(NREGS)-1:0] Rs2E,
  output logic [$clog2(NREGS)-1:0] RdE,
  output logic [XLEN-1:0]          RD1E,
  output logic [XLEN-1:0]          RD2E,
  output logic [XLEN-1:0]          ImmExtE,
  output logic [XLEN-1:0]          PCE,
  output logic [XLEN-1:0]          PCPlus4E,
  output logic [CNT_W-1:0]         BubbleCnt
);

  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } idex_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [6:0]             op;
  logic [2:0]             f3;
  logic                   reg_write, alu_src, mem_write, branch, jump;
  logic [1:0]             imm_src, result_src, alu_op;
  logic [2:0]             alu_control;
  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_ext;
  logic [AW-1:0]          rs1, rs2;
  logic [XLEN-1:0]        rd1, rd2;
  logic [XLEN-1:0]        rf [NREGS];
  idex_t                  idex_p0, idex_p1;
  logic                   vld_p1;
  logic [CNT_W-1:0]       cnt_p1;

  assign op  = InstrD[6:0];
  assign f3  = InstrD[14:12];
  assign rs1 = InstrD[15 +: AW];
  assign rs2 = InstrD[20 +: AW];

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    case (op)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0100011: begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
      7'b1101111: begin reg_write = 1'b1; imm_src = 2'b11; result_src = 2'b10; jump = 1'b1; end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7[5]; addi never subtracts.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  alu_control = (op[5] & InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (imm_src)
      2'b01:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11:   imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  assign imm_ext = XLEN'(imm32);

  // x0 is hardwired to zero and never bypassed.
  always_comb begin
    rd1 = rf[rs1];
    if (rs1 == '0)
      rd1 = '0;
    else if (BYPASS != 0 && RegWriteW && RdW == rs1)
      rd1 = ResultW;
    rd2 = rf[rs2];
    if (rs2 == '0)
      rd2 = '0;
    else if (BYPASS != 0 && RegWriteW && RdW == rs2)
      rd2 = ResultW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (RegWriteW && RdW != '0) begin
      rf[RdW] <= ResultW;
    end
  end

  assign StallD = ValidD && vld_p1 && idex_p1.result_src == 2'b01 && idex_p1.rd != '0 &&
                  (idex_p1.rd == rs1 || idex_p1.rd == rs2) && !HoldE;

  // ---- D stage: decoded bundle; control is zeroed for an empty slot ----
  always_comb begin
    idex_p0     = '0;
    idex_p0.rs1 = rs1;
    idex_p0.rs2 = rs2;
    idex_p0.rd  = InstrD[7 +: AW];
    idex_p0.rd1 = rd1;
    idex_p0.rd2 = rd2;
    idex_p0.imm = imm_ext;
    idex_p0.pc  = PCD;
    idex_p0.pc4 = PCPlus4D;
    if (ValidD) begin
      idex_p0.reg_write   = reg_write;
      idex_p0.result_src  = result_src;
      idex_p0.mem_write   = mem_write;
      idex_p0.jump        = jump;
      idex_p0.branch      = branch;
      idex_p0.alu_control = alu_control;
      idex_p0.alu_src     = alu_src;
    end
  end

  // ---- ID/EX register: flush > hold > load-use bubble > load ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      idex_p1 <= '0;
      cnt_p1  <= '0;
    end else if (FlushE) begin
      vld_p1  <= 1'b0;
      idex_p1 <= '0;
    end else if (!HoldE) begin
      if (StallD) begin
        vld_p1  <= 1'b0;
        idex_p1 <= '0;
        cnt_p1  <= sat_inc(cnt_p1);
      end else begin
        vld_p1  <= ValidD;
        idex_p1 <= idex_p0;
      end
    end
  end

  assign ValidE      = vld_p1;
  assign RegWriteE   = idex_p1.reg_write;
  assign ALUSrcE     = idex_p1.alu_src;
  assign MemWriteE   = idex_p1.mem_write;
  assign BranchE     = idex_p1.branch;
  assign JumpE       = idex_p1.jump;
  assign ResultSrcE  = idex_p1.result_src;
  assign ALUControlE = idex_p1.alu_control;
  assign Rs1E        = idex_p1.rs1;
  assign Rs2E        = idex_p1.rs2;
  assign RdE         = idex_p1.rd;
  assign RD1E        = idex_p1.rd1;
  assign RD2E        = idex_p1.rd2;
  assign ImmExtE     = idex_p1.imm;
  assign PCE         = idex_p1.pc;
  assign PCPlus4E    = idex_p1.pc4;
  assign BubbleCnt   = cnt_p1;

endmodule

// File: doc/decode_stage_ctl.md
# decode_stage_ctl

Parametrised ID stage with ID/EX pipeline register: decodes `InstrD`, reads an internal `NREGS`×`XLEN` register file with optional W→D write-through bypass, and registers control/data into the EX stage. Over the fixed-32-bit decode stage, it adds:
- a valid bit;
- downstream hold;
- branch flush;
- load-use hazard detection with bubble insertion;
- a saturating bubble counter.

It sits between the fetch-stage pipeline register and the execute stage. It reuses `Control_Unit_Top` and `sign_extend` for opcode and immediate decode.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be ≥ 32.
- `NREGS`, 32: register count, power of two; `AW = $clog2(NREGS)`.
- `BYPASS`, 1: 1 enables write-through from W port to read ports.
- `CNT_W`, 16: bubble counter width.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low. 0 = reset.
- `InstrD`  in  32  instruction in D.
- `PCD`, `PCPlus4D`  in  XLEN  PC and PC+4 in D.
- `ValidD`  in  1  `InstrD` holds a real instruction.
- `HoldE`  in  1  downstream stall; ID/EX keeps its contents.
- `FlushE`  in  1  branch/jump taken; ID/EX loads a bubble.
- `RegWriteW`  in  1  write enable from W.
- `RdW`  in  AW  write address.
- `ResultW`  in  XLEN  write data.
- `StallD`  out  1  load-use stall; upstream must hold F and D.
- `ValidE`  out  1  ID/EX holds a real instruction.
- `RegWriteE`, `ALUSrcE`, `MemWriteE`, `BranchE`, `JumpE`  out  1  registered control.
- `ResultSrcE`  out  2  registered control.
- `ALUControlE`  out  3  registered control.
- `Rs1E`, `Rs2E`, `RdE`  out  AW  register addresses.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  XLEN  registered data.
- `BubbleCnt`  out  CNT_W  count of load-use bubbles; saturates at all-ones.

## Operation
- **Field extraction:**
  - `Rs1D = InstrD[15+:AW]`, `Rs2D = InstrD[20+:AW]`, `RdD = InstrD[7+:AW]`.
  - Upper address bits are ignored when `AW < 5`.
- **Decode:** `Control_Unit_Top` decodes `InstrD`. `sign_extend` output is sign-extended from bit 31 to XLEN.
- **Register file:**
  - x0 reads 0, and writes to x0 are ignored.
  - Write on rising `clk` when `RegWriteW && RdW != 0`.
  - All entries clear to 0 on reset.
- **Bypass:** when `BYPASS=1 && RegWriteW && RdW != 0 && RdW == RsxD`, the read data equals `ResultW`, combinationally, in the same cycle. When `BYPASS=0`, the read returns the old value.
- **Load-use:** `StallD = ValidD && ValidE && ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !HoldE`.
- **ID/EX update, per rising edge, in priority order:**
  1. `FlushE`: bubble.
  2. `HoldE`: hold all fields, including `ValidE`.
  3. `StallD`: bubble, and `BubbleCnt` increments.
  4. Otherwise: load decoded fields, with `ValidE <= ValidD`.
- **Bubble:** every ID/EX output becomes 0, including `ValidE`.
- **Invalid decode input:** when `ValidD = 0`, the stage loads all-zero control, so no side effects reach EX.
- **`BubbleCnt`:** increments only on a load-use bubble, not on a flush bubble. It holds at `2^CNT_W-1`.

## Timing
- **Reset:** asserting `rst=0` asynchronously clears every output to 0. This covers all ID/EX fields, `ValidE`, `BubbleCnt` and the register file. `StallD` is 0 during reset because `ValidE = 0`.
- **Latency:** one cycle from D inputs to E outputs. All E outputs come directly from flops.
- **`StallD`:** combinational from `InstrD`/`ValidD` and the E flops, valid in the same cycle.
  - It asserts for exactly one cycle per load-use pair.
  - The following cycle has `ValidE = 0`, so `StallD` deasserts.
- **Simultaneous events:**
  - `FlushE` and `HoldE` together: flush wins.
  - `FlushE` and `StallD` together: bubble, with no count.
  - `HoldE` and write-back together: the regfile write still occurs. Held `RD1E`/`RD2E` are not refreshed; EX forwarding covers this case.
- **Reset release:** the first edge after `rst` goes high performs a normal load.
- **Reset mid-operation:** all state is discarded, with no partial update.

## Test plan
- Reset, then `InstrD=0x00500093` (addi x1,x0,5), `ValidD=1`, `PCD=0x100` → next cycle `ValidE=1`, `RegWriteE=1`, `ALUSrcE=1`, `RdE=1`, `ImmExtE=5`, `PCE=0x100`, `PCPlus4E=0x104`.
- `RegWriteW=1`, `RdW=3`, `ResultW=0xDEADBEEF`, with the same-cycle `InstrD` reading rs1=x3:
  - `BYPASS=1` → `RD1E=0xDEADBEEF` next cycle.
  - `BYPASS=0` → prior value, 0.
- lw x5,0(x2) followed by add x6,x5,x1:
  - `StallD=1` for one cycle, then the next E is a bubble (`ValidE=0`, all control 0) and `BubbleCnt=1`.
  - The add reaches E on the following cycle.
- `HoldE=1` for 3 cycles with a changing `InstrD` → E outputs frozen. `FlushE=1` with `HoldE=1` → `ValidE=0` next cycle, `BubbleCnt` unchanged.
- Write x0 with `ResultW=0x1234`, then read x0 → `RD1E=0`. Bypass does not apply to x0.
- Drive `rst=0` asynchronously mid-cycle with `ValidE=1` → all outputs are 0 before the next edge. After release, all regfile reads return 0.
